sn74xx597_frame: RTL and testbench

//  Parametrised successor of the 8-bit latched shift register ('597 class).

---
 rtl/sn74xx597_frame_if.sv | 26 ++
 rtl/sn74xx597_frame.sv | 99 +++++++++
 tb/tb_sn74xx597_frame.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sn74xx597_frame_if.sv
// Control/data bus of the sn74xx597_frame serializer.
// The master drives the controls; the slave is the serializer itself.
interface sn74xx597_frame_if #(parameter int WIDTH = 8);
  logic             sclr;
  logic             rld;
  logic [WIDTH-1:0] din;
  logic             cload;
  logic             sen;
  logic             dir;
  logic             ser;
  logic             start;
  logic [WIDTH-1:0] q;
  logic             qs;
  logic             busy;
  logic             done;

  modport master (
    output sclr, rld, din, cload, sen, dir, ser, start,
    input  q, qs, busy, done
  );

  modport slave (
    input  sclr, rld, din, cload, sen, dir, ser, start,
    output q, qs, busy, done
  );
endinterface

// File: rtl/sn74xx597_frame.sv
// Parametrised '597-style latched shift register: storage register feeding a
// bidirectional shifter, with an auto-frame sequencer that shifts out a whole word.
module sn74xx597_frame #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic               clk,
  input  logic               rst,
  sn74xx597_frame_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] storage;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;
  logic             dir_r;
  logic             busy;
  logic             done;
  logic             eff_dir;

  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] v,
                                               input logic d, input logic s);
    if (d) return {s, v[WIDTH-1:1]};
    else   return {v[WIDTH-2:0], s};
  endfunction

  // Storage is independent of the frame; its old value is what every transfer sees.
  always_ff @(posedge clk) begin
    if (rst)          storage <= INIT;
    else if (bus.rld) storage <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
      dir_r <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.sclr) begin
        state <= IDLE;
        q     <= '0;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              q     <= storage;
              dir_r <= bus.dir;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= SHIFT;
            end else if (bus.cload) begin
              q <= storage;
            end else if (bus.sen) begin
              q <= shifted(q, bus.dir, bus.ser);
            end
          end
          SHIFT: begin
            q <= shifted(q, dir_r, bus.ser);
            if (cnt == LAST) begin
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // The direction is frozen for the length of a frame so qs always tracks the leaving bit.
  assign eff_dir  = (state == SHIFT) ? dir_r : bus.dir;
  assign bus.qs   = eff_dir ? q[0] : q[WIDTH-1];
  assign bus.q    = q;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_sn74xx597_frame.sv
// Bench for sn74xx597_frame: an 8-bit and a 5-bit instance checked every cycle
// against a word-level model, plus directed literal expectations.
module tb_sn74xx597_frame;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sn74xx597_frame_if #(.WIDTH(8)) b8 ();
  sn74xx597_frame_if #(.WIDTH(5)) b5 ();

  sn74xx597_frame #(.WIDTH(8), .INIT(8'h5A)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
  sn74xx597_frame #(.WIDTH(5), .INIT(5'h13)) dut5 (.clk(clk), .rst(rst), .bus(b5.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state, index 0 = 8-bit instance, 1 = 5-bit instance.
  logic [7:0] mstore [2];
  logic [7:0] mq     [2];
  logic       mbusy  [2];
  logic       mdone  [2];
  logic       mdir   [2];
  int         mleft  [2];
  int         mw     [2] = '{8, 5};
  logic [7:0] minit  [2] = '{8'h5A, 8'h13};

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] model_shift(input logic [7:0] v, input logic d,
                                             input logic s, input int w);
    logic [7:0] m;
    m = 8'((1 << w) - 1);
    if (!d) return 8'((v << 1) | 8'(s)) & m;
    return (v >> 1) | 8'(int'(s) << (w - 1));
  endfunction

  function automatic logic model_qs(input int i, input logic live_dir);
    logic d;
    d = mbusy[i] ? mdir[i] : live_dir;
    return d ? mq[i][0] : mq[i][mw[i]-1];
  endfunction

  task automatic model_step(input int i, input logic r, input logic sc, input logic ld,
                            input logic [7:0] d, input logic cl, input logic sn,
                            input logic dr, input logic sr, input logic st);
    logic [7:0] next_store;
    next_store = ld ? d : mstore[i];
    mdone[i] = 1'b0;
    if (r) begin
      mstore[i] = minit[i];
      mq[i]     = '0;
      mbusy[i]  = 1'b0;
      mleft[i]  = 0;
      mdir[i]   = 1'b0;
      return;
    end
    if (sc) begin
      mq[i]    = '0;
      mbusy[i] = 1'b0;
    end else if (!mbusy[i]) begin
      if (st) begin
        mq[i]    = mstore[i];
        mdir[i]  = dr;
        mbusy[i] = 1'b1;
        mleft[i] = mw[i];
      end else if (cl) begin
        mq[i] = mstore[i];
      end else if (sn) begin
        mq[i] = model_shift(mq[i], dr, sr, mw[i]);
      end
    end else begin
      mq[i] = model_shift(mq[i], mdir[i], sr, mw[i]);
      mleft[i]--;
      if (mleft[i] == 0) begin
        mbusy[i] = 1'b0;
        mdone[i] = 1'b1;
      end
    end
    mstore[i] = next_store;
  endtask

  // Advance the model on each edge, then compare once the DUT has settled.
  always @(posedge clk) begin
    model_step(0, rst, b8.sclr, b8.rld, b8.din, b8.cload, b8.sen, b8.dir, b8.ser, b8.start);
    model_step(1, rst, b5.sclr, b5.rld, 8'(b5.din), b5.cload, b5.sen, b5.dir, b5.ser, b5.start);
    #1;
    checkOutput("m8_q",    b8.q,          mq[0]);
    checkOutput("m8_qs",   8'(b8.qs),     8'(model_qs(0, b8.dir)));
    checkOutput("m8_busy", 8'(b8.busy),   8'(mbusy[0]));
    checkOutput("m8_done", 8'(b8.done),   8'(mdone[0]));
    checkOutput("m5_q",    8'(b5.q),      mq[1]);
    checkOutput("m5_qs",   8'(b5.qs),     8'(model_qs(1, b5.dir)));
    checkOutput("m5_busy", 8'(b5.busy),   8'(mbusy[1]));
    checkOutput("m5_done", 8'(b5.done),   8'(mdone[1]));
  end

  initial begin
    logic [7:0] exp2;
    logic [7:0] exp3;
    logic [7:0] exp6;
    errors = 0;
    checks = 0;
    exp2 = 8'b1111_0000;
    exp3 = 8'hA5;
    exp6 = 8'h13;

    rst = 1'b1;
    {b8.sclr, b8.rld, b8.cload, b8.sen, b8.dir, b8.ser, b8.start} = '0;
    {b5.sclr, b5.rld, b5.cload, b5.sen, b5.dir, b5.ser, b5.start} = '0;
    b8.din = '0;
    b5.din = '0;

    // Reset state, then expose the storage reset value through the shifter.
    applyStimulus(1);
    checkOutput("rst_q",    b8.q,        8'h00);
    checkOutput("rst_qs",   8'(b8.qs),   8'h00);
    checkOutput("rst_busy", 8'(b8.busy), 8'h00);
    checkOutput("rst_done", 8'(b8.done), 8'h00);
    rst = 1'b0;
    b8.cload = 1'b1;
    b5.cload = 1'b1;
    applyStimulus(1);
    checkOutput("init8", b8.q,     8'h5A);
    checkOutput("init5", 8'(b5.q), 8'h13);
    b8.cload = 1'b0;
    b5.cload = 1'b0;

    // Manual shifting toward MSB.
    b8.rld = 1'b1;
    b8.din = 8'h0F;
    applyStimulus(1);
    b8.rld   = 1'b0;
    b8.cload = 1'b1;
    applyStimulus(1);
    b8.cload = 1'b0;
    checkOutput("t2_load", b8.q, 8'h0F);
    b8.dir = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) checkOutput("t2_q4", b8.q, 8'hFF);
      b8.ser = (k < 4);
      b8.sen = 1'b1;
      checkOutput("t2_qs", 8'(b8.qs), 8'(exp2[k]));
      applyStimulus(1);
    end
    b8.sen = 1'b0;
    checkOutput("t2_q8", b8.q, 8'hF0);

    // Auto frame toward LSB; dir toggled mid-frame must not matter.
    b8.rld = 1'b1;
    b8.din = 8'hA5;
    applyStimulus(1);
    b8.rld   = 1'b0;
    b8.dir   = 1'b1;
    b8.ser   = 1'b0;
    b8.start = 1'b1;
    applyStimulus(1);
    b8.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checkOutput("t3_busy", 8'(b8.busy), 8'h01);
      checkOutput("t3_qs",   8'(b8.qs),   8'(exp3[k]));
      if (k == 3) b8.dir = 1'b0;
      applyStimulus(1);
    end
    checkOutput("t3_done", 8'(b8.done), 8'h01);
    checkOutput("t3_idle", 8'(b8.busy), 8'h00);
    checkOutput("t3_q",    b8.q,        8'h00);
    applyStimulus(1);
    checkOutput("t3_done_clr", 8'(b8.done), 8'h00);

    // rld with cload on the same edge transfers the old word.
    b8.rld = 1'b1;
    b8.din = 8'h3C;
    applyStimulus(1);
    b8.din   = 8'hC3;
    b8.cload = 1'b1;
    applyStimulus(1);
    checkOutput("t4_old", b8.q, 8'h3C);
    b8.rld = 1'b0;
    applyStimulus(1);
    checkOutput("t4_new", b8.q, 8'hC3);
    b8.cload = 1'b0;

    // Frame aborted by sclr; cload/sen ignored while busy.
    b8.ser   = 1'b1;
    b8.start = 1'b1;
    applyStimulus(1);
    b8.start = 1'b0;
    b8.cload = 1'b1;
    b8.sen   = 1'b1;
    checkOutput("t5_c0", b8.q, 8'hC3);
    applyStimulus(1);
    checkOutput("t5_c1", b8.q, 8'h87);
    applyStimulus(1);
    checkOutput("t5_c2", b8.q, 8'h0F);
    applyStimulus(1);
    checkOutput("t5_c3", b8.q, 8'h1F);
    b8.cload = 1'b0;
    b8.sen   = 1'b0;
    b8.sclr  = 1'b1;
    applyStimulus(1);
    b8.sclr = 1'b0;
    checkOutput("t5_q",    b8.q,        8'h00);
    checkOutput("t5_busy", 8'(b8.busy), 8'h00);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t5_nodone", 8'(b8.done), 8'h00);
      applyStimulus(1);
    end

    // 5-bit instance: back-to-back frames with start held, then reset mid-frame.
    b5.dir   = 1'b0;
    b5.ser   = 1'b0;
    b5.start = 1'b1;
    applyStimulus(1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("t6_busy", 8'(b5.busy), 8'h01);
      checkOutput("t6_qs",   8'(b5.qs),   8'(exp6[4-k]));
      applyStimulus(1);
    end
    checkOutput("t6_done", 8'(b5.done), 8'h01);
    checkOutput("t6_gap",  8'(b5.busy), 8'h00);
    applyStimulus(1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t6_busy2", 8'(b5.busy), 8'h01);
      if (k < 2) applyStimulus(1);
    end
    rst = 1'b1;
    applyStimulus(1);
    rst      = 1'b0;
    b5.start = 1'b0;
    checkOutput("t6_rst_busy", 8'(b5.busy), 8'h00);
    checkOutput("t6_rst_done", 8'(b5.done), 8'h00);
    checkOutput("t6_rst_q",    8'(b5.q),    8'h00);
    applyStimulus(1);
    checkOutput("t6_nodone", 8'(b5.done), 8'h00);
    b5.cload = 1'b1;
    applyStimulus(1);
    b5.cload = 1'b0;
    checkOutput("t6_init", 8'(b5.q), 8'h13);
    applyStimulus(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
